// File: rtl/cpu_pkg.sv
// Shared types for the TD4 4-bit core: opcode encoding and datapath select codes.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_A  = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_B  = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_IM = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {SRC_A, SRC_B, SRC_IN, SRC_ZERO} src_sel_t;

  typedef enum logic [2:0] {DST_A, DST_B, DST_OUT, DST_PC, DST_NONE} dst_sel_t;

endpackage

// File: rtl/td4_decoder.sv
// Combinational instruction decode: picks adder source, destination and jump outcome.
module td4_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       c,
  output src_sel_t   src_sel,
  output dst_sel_t   dst_sel,
  output logic       imm_zero,
  output logic       jump_taken
);

  // Unlisted opcodes fall through as NOP: 0 + 0 keeps the carry clear.
  always_comb begin
    src_sel    = SRC_ZERO;
    dst_sel    = DST_NONE;
    imm_zero   = 1'b1;
    jump_taken = 1'b0;
    case (opcode)
      OP_ADD_A:  begin src_sel = SRC_A;    dst_sel = DST_A;   imm_zero = 1'b0; end
      OP_ADD_B:  begin src_sel = SRC_B;    dst_sel = DST_B;   imm_zero = 1'b0; end
      OP_MOV_A:  begin src_sel = SRC_ZERO; dst_sel = DST_A;   imm_zero = 1'b0; end
      OP_MOV_B:  begin src_sel = SRC_ZERO; dst_sel = DST_B;   imm_zero = 1'b0; end
      OP_MOV_AB: begin src_sel = SRC_B;    dst_sel = DST_A;   end
      OP_MOV_BA: begin src_sel = SRC_A;    dst_sel = DST_B;   end
      OP_IN_A:   begin src_sel = SRC_IN;   dst_sel = DST_A;   end
      OP_IN_B:   begin src_sel = SRC_IN;   dst_sel = DST_B;   end
      OP_OUT_B:  begin src_sel = SRC_B;    dst_sel = DST_OUT; end
      OP_OUT_IM: begin src_sel = SRC_ZERO; dst_sel = DST_OUT; imm_zero = 1'b0; end
      OP_JMP: begin
        src_sel    = SRC_ZERO;
        dst_sel    = DST_PC;
        imm_zero   = 1'b0;
        jump_taken = 1'b1;
      end
      OP_JNC: begin
        src_sel    = SRC_ZERO;
        dst_sel    = DST_PC;
        imm_zero   = 1'b0;
        jump_taken = ~c;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/td4_core.sv
// Single-cycle TD4 execution core: PC, A, B, carry and output port around one 4-bit adder.
module td4_core
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [3:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] out_port,
  output logic [3:0] reg_a,
  output logic [3:0] reg_b,
  output logic       carry
);

  logic [3:0] pc, a, b, outr;
  logic       c;
  src_sel_t   src_sel;
  dst_sel_t   dst_sel;
  logic       imm_zero, jump_taken;
  logic [3:0] src, imm;
  logic [4:0] sum;

  td4_decoder u_dec (
    .opcode     (rom_data[7:4]),
    .c          (c),
    .src_sel    (src_sel),
    .dst_sel    (dst_sel),
    .imm_zero   (imm_zero),
    .jump_taken (jump_taken)
  );

  always_comb begin
    src = 4'd0;
    case (src_sel)
      SRC_A:   src = a;
      SRC_B:   src = b;
      SRC_IN:  src = in_port;
      default: src = 4'd0;
    endcase
  end

  assign imm = imm_zero ? 4'd0 : rom_data[3:0];
  assign sum = {1'b0, src} + {1'b0, imm};

  // Jumps route Im through the adder with a zero source, so sum[3:0] is the target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= 4'd0;
      a    <= 4'd0;
      b    <= 4'd0;
      outr <= 4'd0;
      c    <= 1'b0;
    end else if (en) begin
      c  <= sum[4];
      pc <= jump_taken ? sum[3:0] : pc + 4'd1;
      case (dst_sel)
        DST_A:   a    <= sum[3:0];
        DST_B:   b    <= sum[3:0];
        DST_OUT: outr <= sum[3:0];
        default: ;
      endcase
    end
  end

  assign rom_addr = pc;
  assign out_port = outr;
  assign reg_a    = a;
  assign reg_b    = b;
  assign carry    = c;

endmodule

// File: tb/tb_td4_core.sv
// Bench for td4_core: ISA-level reference model, per-cycle compare, directed and random programs.
module tb_td4_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] in_port;
  logic [3:0] out_port;
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic       carry;

  logic [7:0] rom [16];
  int checks = 0;
  int errors = 0;

  logic [3:0] m_pc, m_a, m_b, m_out;
  logic       m_c;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  td4_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .in_port  (in_port),
    .out_port (out_port),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .carry    (carry)
  );

  // Reference model: architectural effect of each instruction on the machine state.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 0; m_a = 0; m_b = 0; m_out = 0; m_c = 0;
    end else if (en) begin
      logic [3:0] op, im, nxt;
      logic       c_new;
      int         t;
      op    = rom[m_pc][7:4];
      im    = rom[m_pc][3:0];
      nxt   = m_pc + 4'd1;
      c_new = 1'b0;
      case (op)
        4'd0:  begin t = int'(m_a) + int'(im); m_a = 4'(t % 16); c_new = (t > 15); end
        4'd5:  begin t = int'(m_b) + int'(im); m_b = 4'(t % 16); c_new = (t > 15); end
        4'd3:  m_a = im;
        4'd7:  m_b = im;
        4'd1:  m_a = m_b;
        4'd4:  m_b = m_a;
        4'd2:  m_a = in_port;
        4'd6:  m_b = in_port;
        4'd9:  m_out = m_b;
        4'd11: m_out = im;
        4'd15: nxt = im;
        4'd14: if (!m_c) nxt = im;
        default: ;
      endcase
      m_c  = c_new;
      m_pc = nxt;
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("pc",    rom_addr, m_pc);
    check("a",     reg_a,    m_a);
    check("b",     reg_b,    m_b);
    check("out",   out_port, m_out);
    check("carry", {3'b0, carry}, {3'b0, m_c});
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b1;
    in_port = 4'h0;
    clear_rom();

    // Reset held with en=1
    step(3);
    check("rst_pc", rom_addr, 4'h0);
    check("rst_a", reg_a, 4'h0);
    check("rst_b", reg_b, 4'h0);
    check("rst_out", out_port, 4'h0);
    check("rst_c", {3'b0, carry}, 4'h0);

    // Overflow loop: MOV A,13; ADD A,1; JNC 1; JMP 3
    clear_rom();
    rom[0] = 8'h3D; rom[1] = 8'h01; rom[2] = 8'hE1; rom[3] = 8'hF3;
    do_reset();
    step(1); check("ovf_a13", reg_a, 4'hD);
    step(1); check("ovf_a14", reg_a, 4'hE);
    step(1); check("ovf_jnc_taken", rom_addr, 4'h1);
    step(3); check("ovf_a0", reg_a, 4'h0);
    check("ovf_carry", {3'b0, carry}, 4'h1);
    step(1); check("ovf_fall", rom_addr, 4'h3);
    check("ovf_carry_clr", {3'b0, carry}, 4'h0);

    // Input/output
    clear_rom();
    rom[0] = 8'h60; rom[1] = 8'h90; rom[2] = 8'hBF;
    in_port = 4'hA;
    do_reset();
    step(1); check("io_b", reg_b, 4'hA);
    check("io_out_hold", out_port, 4'h0);
    step(1); check("io_out_b", out_port, 4'hA);
    step(1); check("io_out_im", out_port, 4'hF);

    // JMP 7 from PC 9
    clear_rom();
    rom[0] = 8'hF9; rom[9] = 8'hF7;
    do_reset();
    step(1); check("jmp_pc9", rom_addr, 4'h9);
    step(1); check("jmp_pc7", rom_addr, 4'h7);
    check("jmp_carry", {3'b0, carry}, 4'h0);

    // PC wrap 15 -> 0
    clear_rom();
    rom[0] = 8'hFF; rom[15] = 8'h35;
    do_reset();
    step(2); check("wrap_pc", rom_addr, 4'h0);
    check("wrap_a", reg_a, 4'h5);

    // Enable hold with C=1, then NOP clears C
    clear_rom();
    rom[0] = 8'h3F; rom[1] = 8'h01; rom[2] = 8'h80;
    do_reset();
    step(2); check("hold_c_pre", {3'b0, carry}, 4'h1);
    #1 en = 1'b0;
    step(5);
    check("hold_pc", rom_addr, 4'h2);
    check("hold_c", {3'b0, carry}, 4'h1);
    check("hold_a", reg_a, 4'h0);
    #1 en = 1'b1;
    step(1);
    check("nop_pc", rom_addr, 4'h3);
    check("nop_c", {3'b0, carry}, 4'h0);
    check("nop_a", reg_a, 4'h0);

    // Mid-cycle asynchronous reset
    rom[3] = 8'h37;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_pc", rom_addr, 4'h0);
    check("async_a", reg_a, 4'h0);
    check("async_c", {3'b0, carry}, 4'h0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Random programs, inputs, enable and occasional reset
    for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      #1;
      en = ($urandom_range(0, 7) != 0);
      in_port = 4'($urandom);
      rst_n = ($urandom_range(0, 99) != 0);
      if (cyc % 200 == 199) begin
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      end
      if (!rst_n) begin
        #2 rst_n = 1'b1;
      end
    end

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
